// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared widths, state encoding and helpers for the imem program loader
package loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int COUNT_W        = 16;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        COUNT_HI,
        COUNT_LO,
        DATA,
        CHECK,
        RUN,
        ERROR
    } loader_state_e;

    // A frame must carry at least one word and no more than the memory holds.
    function automatic logic count_in_range(input logic [COUNT_W-1:0] n, input int max_words);
        return (n != '0) && (int'(n) <= max_words);
    endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// rtl/byte_to_word_packer.sv - packs big-endian bytes into 32-bit words and keeps a running XOR
module byte_to_word_packer
    import loader_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clear,
    input  logic                i_byte_valid,
    input  logic [BYTE_W-1:0]   i_byte,
    output logic [1:0]          o_byte_idx,
    output logic                o_word_valid,
    output logic [WORD_W-1:0]   o_word,
    output logic [BYTE_W-1:0]   o_csum
);

    logic [1:0]               r_idx;
    logic [WORD_W-BYTE_W-1:0] r_shift;
    logic                     r_word_valid;
    logic [WORD_W-1:0]        r_word;
    logic [BYTE_W-1:0]        r_csum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx        <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
            r_csum       <= '0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_idx   <= '0;
                r_shift <= '0;
                r_csum  <= '0;
            end else if (i_byte_valid) begin
                r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
                r_idx   <= r_idx + 2'd1;
                r_csum  <= r_csum ^ i_byte;
                // First byte received lands in the top bits once all four are in.
                if (r_idx == 2'(BYTES_PER_WORD-1)) begin
                    r_word_valid <= 1'b1;
                    r_word       <= {r_shift, i_byte};
                end
            end
        end
    end

    assign o_byte_idx   = r_idx;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;
    assign o_csum       = r_csum;

endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - framed byte-stream loader that fills instruction memory and releases the CPU
module imem_program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
)
(
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_load_start,
    input  logic                  i_in_valid,
    input  logic [BYTE_W-1:0]     i_in_data,
    output logic                  o_in_ready,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [WORD_W-1:0]     o_imem_wdata,
    output logic                  o_cpu_run,
    output logic                  o_load_busy,
    output logic                  o_load_error
);

    localparam int MAX_WORDS = 2**ADDR_WIDTH;

    loader_state_e           r_state;
    logic [BYTE_W-1:0]       r_count_hi;
    logic [COUNT_W-1:0]      r_count;
    logic [ADDR_WIDTH:0]     r_word_idx;
    logic [ADDR_WIDTH-1:0]   r_imem_addr;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_data_byte;
    logic                    w_word_done;
    logic                    w_last_word;
    logic [COUNT_W-1:0]      w_count_rx;
    logic [1:0]              w_byte_idx;
    logic                    w_word_valid;
    logic [WORD_W-1:0]       w_word;
    logic [BYTE_W-1:0]       w_csum;

    // load_start wins over any byte on the same cycle, so it also closes the handshake.
    assign w_in_ready  = i_reset_n && !i_load_start &&
                         ((r_state == COUNT_HI) || (r_state == COUNT_LO) ||
                          (r_state == DATA)     || (r_state == CHECK));
    assign w_accept    = i_in_valid && w_in_ready;
    assign w_data_byte = w_accept && (r_state == DATA);
    assign w_word_done = w_data_byte && (w_byte_idx == 2'(BYTES_PER_WORD-1));
    assign w_last_word = ((COUNT_W'(r_word_idx) + COUNT_W'(1)) == r_count);
    assign w_count_rx  = {r_count_hi, i_in_data};

    byte_to_word_packer u_packer (
        .i_clk        (i_clock),
        .i_rst_n      (i_reset_n),
        .i_clear      (i_load_start),
        .i_byte_valid (w_data_byte),
        .i_byte       (i_in_data),
        .o_byte_idx   (w_byte_idx),
        .o_word_valid (w_word_valid),
        .o_word       (w_word),
        .o_csum       (w_csum)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= COUNT_HI;
            r_count_hi  <= '0;
            r_count     <= '0;
            r_word_idx  <= '0;
            r_imem_addr <= '0;
        end else if (i_load_start) begin
            r_state    <= COUNT_HI;
            r_count_hi <= '0;
            r_count    <= '0;
            r_word_idx <= '0;
        end else begin
            case (r_state)
                COUNT_HI: begin
                    if (w_accept) begin
                        r_count_hi <= i_in_data;
                        r_state    <= COUNT_LO;
                    end
                end
                COUNT_LO: begin
                    if (w_accept) begin
                        r_count <= w_count_rx;
                        r_state <= count_in_range(w_count_rx, MAX_WORDS) ? DATA : ERROR;
                    end
                end
                DATA: begin
                    // Address is captured alongside the packer's word so both appear together.
                    if (w_word_done) begin
                        r_imem_addr <= r_word_idx[ADDR_WIDTH-1:0];
                        r_word_idx  <= r_word_idx + 1'b1;
                        if (w_last_word) begin
                            r_state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (w_accept) begin
                        r_state <= (i_in_data == w_csum) ? RUN : ERROR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_imem_we    = w_word_valid;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = w_word;
    assign o_cpu_run    = (r_state == RUN);
    assign o_load_error = (r_state == ERROR);
    assign o_load_busy  = (r_state == COUNT_LO) || (r_state == DATA) || (r_state == CHECK);

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - scoreboard bench for imem_program_loader
module tb_imem_program_loader;

    localparam int AW   = 8;
    localparam int MAXW = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_run;
    logic          load_busy;
    logic          load_error;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] mem   [MAXW];
    logic [31:0] words [MAXW];

    imem_program_loader #(.ADDR_WIDTH(AW)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_load_start (load_start),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_wdata (imem_wdata),
        .o_cpu_run    (cpu_run),
        .o_load_busy  (load_busy),
        .o_load_error (load_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model and write scoreboard.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            mem[imem_addr] <= imem_wdata;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e.addr));
                chk("write_data", imem_wdata, e.data);
            end
        end
    end

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   cyc = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = in_ready;
            to_pos();
            cyc++;
        end
        in_valid = 1'b0;
        chk("byte_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        to_pos();
        load_start = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit bad_csum, input bit gaps, input bit lat_chk);
        logic [7:0]  cs = 8'h00;
        logic [7:0]  bt;
        logic [15:0] nn;
        logic [31:0] w;
        nn = 16'(n);
        send_byte(nn[15:8]);
        send_byte(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int b = 0; b < 4; b++) begin
                bt = w[31-8*b -: 8];
                if (gaps) idle(int'($urandom_range(0, 2)));
                if (b == 3) exp_q.push_back('{addr: AW'(i), data: w});
                send_byte(bt);
                cs = cs ^ bt;
            end
            if (lat_chk && i == 0) begin
                @(negedge clk);
                chk("first_write_latency", 32'(imem_we), 32'd1);
                to_pos();
            end
        end
        @(negedge clk);
        chk("cpu_run_before_csum", 32'(cpu_run), 32'd0);
        to_pos();
        send_byte(bad_csum ? 8'h00 : cs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_we",    32'(imem_we),    32'd0);
        chk("rst_imem_addr",  32'(imem_addr),  32'd0);
        chk("rst_imem_wdata", imem_wdata,      32'd0);
        chk("rst_cpu_run",    32'(cpu_run),    32'd0);
        chk("rst_load_error", 32'(load_error), 32'd0);
        chk("rst_load_busy",  32'(load_busy),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        to_pos();

        // Test 1: good two-word frame (checksum 0x0E)
        words[0] = 32'h2008_0005; words[1] = 32'h2009_000A;
        send_frame(2, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_cpu_run",    32'(cpu_run),    32'd1);
        chk("t1_load_error", 32'(load_error), 32'd0);
        chk("t1_in_ready",   32'(in_ready),   32'd0);
        chk("t1_load_busy",  32'(load_busy),  32'd0);
        chk("t1_drained",    32'(exp_q.size()), 32'd0);
        to_pos();
        pulse_load_start();
        @(negedge clk);
        chk("t1_run_drop", 32'(cpu_run), 32'd0);
        to_pos();

        // Test 2: same frame, wrong checksum
        send_frame(2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_load_error", 32'(load_error), 32'd1);
        chk("t2_cpu_run",    32'(cpu_run),    32'd0);
        chk("t2_in_ready",   32'(in_ready),   32'd0);
        chk("t2_drained",    32'(exp_q.size()), 32'd0);
        to_pos();
        pulse_load_start();
        @(negedge clk);
        chk("t2_error_clear", 32'(load_error), 32'd0);
        to_pos();

        // Test 3: N=0 and N=MAX_WORDS+1
        send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        chk("t3_n0_error",    32'(load_error), 32'd1);
        chk("t3_n0_in_ready", 32'(in_ready),   32'd0);
        to_pos();
        pulse_load_start();
        send_byte(8'h01); send_byte(8'h01);
        @(negedge clk);
        chk("t3_nmax1_error", 32'(load_error), 32'd1);
        chk("t3_nmax1_busy",  32'(load_busy),  32'd0);
        to_pos();
        pulse_load_start();

        // Boundary: N=MAX_WORDS fills every address
        for (int i = 0; i < MAXW; i++) words[i] = {8'(i), ~8'(i), 8'hA5 ^ 8'(i), 8'h3C};
        send_frame(MAXW, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("tmax_cpu_run", 32'(cpu_run), 32'd1);
        chk("tmax_mem_255", mem[MAXW-1], {8'hFF, 8'h00, 8'h5A, 8'h3C});
        to_pos();
        pulse_load_start();

        // Test 4: test 1 frame with random valid gaps
        words[0] = 32'h2008_0005; words[1] = 32'h2009_000A;
        send_frame(2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_cpu_run", 32'(cpu_run), 32'd1);
        chk("t4_mem0",    mem[0], 32'h2008_0005);
        chk("t4_mem1",    mem[1], 32'h2009_000A);
        to_pos();
        pulse_load_start();

        // Test 5: load_start mid-DATA with a byte presented
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h20); send_byte(8'h08);
        in_valid = 1'b1; in_data = 8'hAA; load_start = 1'b1;
        @(negedge clk);
        chk("t5_abort_in_ready", 32'(in_ready), 32'd0);
        to_pos();
        load_start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t5_abort_busy", 32'(load_busy), 32'd0);
        to_pos();
        words[0] = 32'h1122_3344; words[1] = 32'h5566_7788;
        send_frame(2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_cpu_run", 32'(cpu_run), 32'd1);
        to_pos();
        pulse_load_start();
        @(negedge clk);
        chk("t5_run_drop", 32'(cpu_run), 32'd0);
        to_pos();

        // Test 6: asynchronous reset mid-DATA
        send_byte(8'h00); send_byte(8'h02);
        exp_q.push_back('{addr: AW'(0), data: 32'hDEAD_BEEF});
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h01); send_byte(8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wdata",  imem_wdata,       32'd0);
        chk("t6_rst_we",     32'(imem_we),     32'd0);
        chk("t6_rst_busy",   32'(load_busy),   32'd0);
        chk("t6_rst_run",    32'(cpu_run),     32'd0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_mem0",     mem[0], 32'hDEAD_BEEF);
        chk("t6_mem1",     mem[1], 32'h5566_7788);
        to_pos();
        words[0] = 32'h1234_5678;
        send_frame(1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_reload_run", 32'(cpu_run), 32'd1);
        chk("t6_reload_mem", mem[0], 32'h1234_5678);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
